// File: rtl/mixer_if_freq_meter.sv
// mixer_if_freq_meter
// Multi-channel edge counter and average-period meter over a programmable
// gate window. Each channel's input is synchronised and its rising edges are
// counted and timestamped against the window counter. At the end of every
// window the results are copied into shadow registers. A single shared
// restoring divider then turns them into average periods, one channel after
// another. The signed count difference between two selectable channels
// estimates the IF.

module mixer_if_freq_meter #(
  parameter int NCH   = 2,
  parameter int CNT_W = 16,
  parameter int WIN_W = 20,
  parameter int SEL_W = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [WIN_W-1:0]         win_len,
  input  logic [NCH-1:0]           sig_in,
  input  logic [SEL_W-1:0]         sel_a,
  input  logic [SEL_W-1:0]         sel_b,
  output logic [NCH*CNT_W-1:0]     edge_cnt,
  output logic [NCH*WIN_W-1:0]     avg_period,
  output logic signed [CNT_W:0]    diff,
  output logic                     valid,
  output logic                     busy,
  output logic [NCH-1:0]           ovf,
  output logic                     overrun
);

  // Remainder/divisor width: wide enough for either a count or a timestamp,
  // plus one guard bit for the shifted partial remainder.
  localparam int DW  = ((CNT_W > WIN_W) ? CNT_W : WIN_W) + 1;
  localparam int STW = $clog2(WIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // ---------------------------------------------------------------------
  // Input synchronisers and edge detection
  // ---------------------------------------------------------------------
  logic [NCH-1:0] sync1_r;
  logic [NCH-1:0] sync2_r;
  logic [NCH-1:0] sync3_r;
  logic [NCH-1:0] rise_s;

  // Two-flop synchroniser per channel plus one delay stage for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= '0;
      sync2_r <= '0;
      sync3_r <= '0;
    end else begin
      sync1_r <= sig_in;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  assign rise_s = sync2_r & ~sync3_r;

  // ---------------------------------------------------------------------
  // Gate window counter
  // ---------------------------------------------------------------------
  logic [WIN_W-1:0] wcnt_r;
  logic [WIN_W-1:0] win_lat_r;
  logic             win_run_s;
  logic             term_s;

  // A window runs while enabled. At wcnt=0 the live win_len decides whether
  // a window starts (it is latched on that cycle). After that the latched
  // length defines the terminal cycle.
  always_comb begin
    win_run_s = 1'b0;
    term_s    = 1'b0;
    if (!en) begin
      win_run_s = 1'b0;
      term_s    = 1'b0;
    end else if (wcnt_r == '0) begin
      win_run_s = (win_len >= WIN_W'(2));
      term_s    = 1'b0;
    end else begin
      win_run_s = 1'b1;
      term_s    = (wcnt_r == (win_lat_r - WIN_W'(1)));
    end
  end

  // Window position counter; wraps gaplessly to 0 after the terminal cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_r    <= '0;
      win_lat_r <= '0;
    end else if (!win_run_s) begin
      wcnt_r    <= '0;
    end else begin
      if (wcnt_r == '0) begin
        win_lat_r <= win_len;
      end
      wcnt_r <= term_s ? '0 : (wcnt_r + WIN_W'(1));
    end
  end

  // ---------------------------------------------------------------------
  // Live per-channel counters and timestamps
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_r      [NCH];
  logic [CNT_W-1:0] cnt_nx_s   [NCH];
  logic [WIN_W-1:0] first_r    [NCH];
  logic [WIN_W-1:0] first_nx_s [NCH];
  logic [WIN_W-1:0] last_r     [NCH];
  logic [WIN_W-1:0] last_nx_s  [NCH];
  logic [NCH-1:0]   ovf_r;
  logic [NCH-1:0]   ovf_nx_s;

  // Next-state of the live counters including an edge seen this cycle. The
  // snapshot uses these values, so an edge on the terminal cycle belongs to
  // the closing window. Once saturated, further edges only set the overflow
  // flag and leave last_ts alone, so the average stays consistent with the
  // stored count.
  always_comb begin
    cnt_nx_s   = cnt_r;
    first_nx_s = first_r;
    last_nx_s  = last_r;
    ovf_nx_s   = ovf_r;
    for (int k = 0; k < NCH; k++) begin
      if (!rise_s[k]) begin
        cnt_nx_s[k] = cnt_r[k];
      end else if (cnt_r[k] == CNT_MAX) begin
        ovf_nx_s[k] = 1'b1;
      end else begin
        cnt_nx_s[k]  = cnt_r[k] + CNT_W'(1);
        last_nx_s[k] = wcnt_r;
        if (cnt_r[k] == '0) begin
          first_nx_s[k] = wcnt_r;
        end else begin
          first_nx_s[k] = first_r[k];
        end
      end
    end
  end

  // Live counters clear when the window is not running and after every
  // terminal cycle, whether or not the snapshot is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        cnt_r[k]   <= '0;
        first_r[k] <= '0;
        last_r[k]  <= '0;
      end
      ovf_r <= '0;
    end else if (!win_run_s || term_s) begin
      for (int k = 0; k < NCH; k++) begin
        cnt_r[k]   <= '0;
        first_r[k] <= '0;
        last_r[k]  <= '0;
      end
      ovf_r <= '0;
    end else begin
      cnt_r   <= cnt_nx_s;
      first_r <= first_nx_s;
      last_r  <= last_nx_s;
      ovf_r   <= ovf_nx_s;
    end
  end

  // ---------------------------------------------------------------------
  // Snapshot registers
  // ---------------------------------------------------------------------
  logic [1:0]       state_r;
  logic             snap_s;
  logic [CNT_W-1:0] sh_cnt_r   [NCH];
  logic [WIN_W-1:0] sh_first_r [NCH];
  logic [WIN_W-1:0] sh_last_r  [NCH];
  logic [NCH-1:0]   sh_ovf_r;
  logic [SEL_W-1:0] sh_sel_a_r;
  logic [SEL_W-1:0] sh_sel_b_r;

  assign snap_s = term_s && (state_r == S_IDLE);

  // Capture the closing window's results when the divider is free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NCH; k++) begin
        sh_cnt_r[k]   <= '0;
        sh_first_r[k] <= '0;
        sh_last_r[k]  <= '0;
      end
      sh_ovf_r   <= '0;
      sh_sel_a_r <= '0;
      sh_sel_b_r <= '0;
    end else if (snap_s) begin
      sh_cnt_r   <= cnt_nx_s;
      sh_first_r <= first_nx_s;
      sh_last_r  <= last_nx_s;
      sh_ovf_r   <= ovf_nx_s;
      sh_sel_a_r <= sel_a;
      sh_sel_b_r <= sel_b;
    end
  end

  // Sticky flag: a window closed while the previous result was still being
  // processed, so its data was lost. Only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (term_s && (state_r != S_IDLE)) begin
      overrun <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Operand selection
  // ---------------------------------------------------------------------
  logic [SEL_W-1:0] ch_r;
  logic [CNT_W-1:0] ld_cnt_s;
  logic [WIN_W-1:0] ld_first_s;
  logic [WIN_W-1:0] ld_last_s;
  logic [CNT_W-1:0] op_a_s;
  logic [CNT_W-1:0] op_b_s;

  // Mux the current channel's shadow data for the divider, and the two diff
  // operands. A select that matches no channel leaves its operand at zero.
  always_comb begin
    ld_cnt_s   = '0;
    ld_first_s = '0;
    ld_last_s  = '0;
    op_a_s     = '0;
    op_b_s     = '0;
    for (int k = 0; k < NCH; k++) begin
      ld_cnt_s   = (ch_r == SEL_W'(k)) ? sh_cnt_r[k]   : ld_cnt_s;
      ld_first_s = (ch_r == SEL_W'(k)) ? sh_first_r[k] : ld_first_s;
      ld_last_s  = (ch_r == SEL_W'(k)) ? sh_last_r[k]  : ld_last_s;
      op_a_s     = (sh_sel_a_r == SEL_W'(k)) ? sh_cnt_r[k] : op_a_s;
      op_b_s     = (sh_sel_b_r == SEL_W'(k)) ? sh_cnt_r[k] : op_b_s;
    end
  end

  // ---------------------------------------------------------------------
  // Restoring divider datapath
  // ---------------------------------------------------------------------
  logic [DW-1:0]    rem_r;
  logic [DW-1:0]    dvs_r;
  logic [DW-1:0]    rem_sh_s;
  logic [DW-1:0]    rem_nx_s;
  logic [WIN_W-1:0] quo_r;
  logic [WIN_W-1:0] quo_nx_s;
  logic [WIN_W-1:0] q_final_s;
  logic             q_bit_s;
  logic             zero_q_r;
  logic [STW-1:0]   step_r;
  logic             div_last_s;
  logic             done_now_s;
  logic [WIN_W-1:0] res_r [NCH];

  // One restoring step. The dividend shifts out of quo_r from the MSB while
  // the quotient bits shift in at the LSB.
  always_comb begin
    rem_sh_s = {rem_r[DW-2:0], quo_r[WIN_W-1]};
    if (rem_sh_s >= dvs_r) begin
      rem_nx_s = rem_sh_s - dvs_r;
      q_bit_s  = 1'b1;
    end else begin
      rem_nx_s = rem_sh_s;
      q_bit_s  = 1'b0;
    end
    quo_nx_s = {quo_r[WIN_W-2:0], q_bit_s};
    if (zero_q_r) begin
      q_final_s = '0;
    end else begin
      q_final_s = quo_nx_s;
    end
  end

  assign div_last_s = (state_r == S_DIV) && (step_r == STW'(WIN_W - 1));
  assign done_now_s = div_last_s && (ch_r == SEL_W'(NCH - 1));

  // Sequencer: for each channel, one LOAD cycle and then WIN_W divide
  // cycles; a single DONE cycle follows the last channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= S_IDLE;
      ch_r     <= '0;
      step_r   <= '0;
      rem_r    <= '0;
      dvs_r    <= '0;
      quo_r    <= '0;
      zero_q_r <= 1'b0;
      busy     <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        res_r[k] <= '0;
      end
    end else begin
      case (state_r)
        S_IDLE: begin
          if (snap_s) begin
            state_r <= S_LOAD;
            ch_r    <= '0;
            busy    <= 1'b1;
          end
        end
        S_LOAD: begin
          dvs_r    <= DW'(ld_cnt_s) - DW'(1);
          zero_q_r <= (ld_cnt_s < CNT_W'(2));
          quo_r    <= ld_last_s - ld_first_s;
          rem_r    <= '0;
          step_r   <= '0;
          state_r  <= S_DIV;
        end
        S_DIV: begin
          rem_r <= rem_nx_s;
          quo_r <= quo_nx_s;
          if (div_last_s) begin
            for (int k = 0; k < NCH; k++) begin
              if (ch_r == SEL_W'(k)) begin
                res_r[k] <= q_final_s;
              end
            end
            if (ch_r == SEL_W'(NCH - 1)) begin
              state_r <= S_DONE;
            end else begin
              ch_r    <= ch_r + SEL_W'(1);
              state_r <= S_LOAD;
            end
          end else begin
            step_r <= step_r + STW'(1);
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Result registers
  // ---------------------------------------------------------------------
  // All outputs update together on entry to DONE, which is also the single
  // cycle that valid is high. The last channel's quotient is taken straight
  // from the divider because it has not reached res_r yet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt   <= '0;
      avg_period <= '0;
      diff       <= '0;
      ovf        <= '0;
      valid      <= 1'b0;
    end else begin
      valid <= done_now_s;
      if (done_now_s) begin
        for (int k = 0; k < NCH; k++) begin
          edge_cnt[k*CNT_W +: CNT_W]   <= sh_cnt_r[k];
          avg_period[k*WIN_W +: WIN_W] <= (k == NCH - 1) ? q_final_s : res_r[k];
        end
        ovf  <= sh_ovf_r;
        diff <= $signed({1'b0, op_a_s} - {1'b0, op_b_s});
      end
    end
  end

endmodule

// File: tb/tb_mixer_if_freq_meter.sv
// Directed testbench for mixer_if_freq_meter. Channel waveforms come from a
// small periodic generator that advances once per clock. Every expected value
// is worked out by hand from the stimulus timing.

module tb_mixer_if_freq_meter;

  logic               clk;
  logic               rst;
  logic               en;
  logic [19:0]        win_len;
  logic [1:0]         sig_in;
  logic [2:0]         sel_a;
  logic [2:0]         sel_b;
  logic [31:0]        edge_cnt;
  logic [39:0]        avg_period;
  logic signed [16:0] diff;
  logic               valid;
  logic               busy;
  logic [1:0]         ovf;
  logic               overrun;

  // Narrow-counter build, used for the saturation check.
  logic [7:0]         edge_cnt4;
  logic [39:0]        avg_period4;
  logic signed [4:0]  diff4;
  logic               valid4;
  logic               busy4;
  logic [1:0]         ovf4;
  logic               overrun4;

  int tests;
  int fails;
  int cyc;
  int vcount;
  int m;
  int r;
  int v0;
  int per [2];
  int ph  [2];

  mixer_if_freq_meter #(.NCH(2), .CNT_W(16), .WIN_W(20), .SEL_W(3)) u_dut (
    .clk(clk), .rst(rst), .en(en), .win_len(win_len), .sig_in(sig_in),
    .sel_a(sel_a), .sel_b(sel_b), .edge_cnt(edge_cnt), .avg_period(avg_period),
    .diff(diff), .valid(valid), .busy(busy), .ovf(ovf), .overrun(overrun)
  );

  mixer_if_freq_meter #(.NCH(2), .CNT_W(4), .WIN_W(20), .SEL_W(3)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .win_len(win_len), .sig_in(sig_in),
    .sel_a(sel_a), .sel_b(sel_b), .edge_cnt(edge_cnt4), .avg_period(avg_period4),
    .diff(diff4), .valid(valid4), .busy(busy4), .ovf(ovf4), .overrun(overrun4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Advance one clock; sample just after the edge, then drive the next inputs.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (valid === 1'b1) vcount++;
    for (int k = 0; k < 2; k++) begin
      if (per[k] != 0) begin
        ph[k] = (ph[k] + 1) % per[k];
        sig_in[k] = (ph[k] < per[k] / 2);
      end else begin
        sig_in[k] = 1'b0;
      end
    end
  endtask

  // Raise every active channel in the current cycle (phase 0).
  task automatic start_gen();
    for (int k = 0; k < 2; k++) begin
      if (per[k] != 0) begin
        ph[k] = 0;
        sig_in[k] = 1'b1;
      end
    end
  endtask

  task automatic wait_valid(input int limit);
    while (valid !== 1'b1 && cyc < limit) tick();
    chk("valid_seen", 64'(valid), 64'd1);
  endtask

  // Restart the window with a fresh phase: the channels rise two cycles
  // before en, so their first edge is detected at wcnt=0.
  task automatic measure(input string tag, input int p0, input int p1, input int wl,
                         input int sa, input int sb, input int exp_lat);
    en = 1'b0;
    per[0] = 0;
    per[1] = 0;
    repeat (4) tick();
    win_len = 20'(wl);
    sel_a = 3'(sa);
    sel_b = 3'(sb);
    per[0] = p0;
    per[1] = p1;
    start_gen();
    tick();
    tick();
    en = 1'b1;
    m = cyc;
    wait_valid(m + exp_lat + 16);
    chk({tag, "_latency"}, 64'(cyc - m), 64'(exp_lat));
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; vcount = 0;
    per[0] = 0; per[1] = 0; ph[0] = 0; ph[1] = 0;
    rst = 1'b1; en = 1'b0; win_len = 20'd0; sig_in = 2'b00;
    sel_a = 3'd0; sel_b = 3'd0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_edge_cnt", 64'(edge_cnt), 64'd0);
    chk("rst_avg", 64'(avg_period), 64'd0);
    chk("rst_diff", 64'(diff), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);

    // ch0 period 10, ch1 period 12 over 1000 cycles
    measure("t1", 10, 12, 1000, 0, 1, 1042);
    chk("t1_cnt0", 64'(edge_cnt[15:0]), 64'd100);
    chk("t1_cnt1", 64'(edge_cnt[31:16]), 64'd84);
    chk("t1_avg0", 64'(avg_period[19:0]), 64'd10);
    chk("t1_avg1", 64'(avg_period[39:20]), 64'd12);
    chk("t1_diff", 64'(diff), 64'(16));
    chk("t1_ovf", 64'(ovf), 64'd0);
    chk("t1_overrun", 64'(overrun), 64'd0);
    tick();
    chk("t1_valid_pulse", 64'(valid), 64'd0);
    chk("t1_busy_after", 64'(busy), 64'd0);

    // Outputs hold while disabled
    en = 1'b0;
    per[0] = 0;
    per[1] = 0;
    repeat (10) tick();
    chk("hold_cnt0", 64'(edge_cnt[15:0]), 64'd100);
    chk("hold_avg1", 64'(avg_period[39:20]), 64'd12);

    // Swapped selects, then an out-of-range select
    measure("t2", 10, 12, 1000, 1, 0, 1042);
    chk("t2_diff", 64'(diff), 64'(-16));
    measure("t3", 10, 12, 1000, 5, 1, 1042);
    chk("t3_diff", 64'(diff), 64'(-84));
    chk("t3_cnt0", 64'(edge_cnt[15:0]), 64'd100);

    // Single edge on ch0, ch1 silent
    measure("t4", 200, 0, 100, 0, 1, 142);
    chk("t4_cnt0", 64'(edge_cnt[15:0]), 64'd1);
    chk("t4_avg0", 64'(avg_period[19:0]), 64'd0);
    chk("t4_cnt1", 64'(edge_cnt[31:16]), 64'd0);
    chk("t4_avg1", 64'(avg_period[39:20]), 64'd0);
    chk("t4_diff", 64'(diff), 64'(1));

    // Saturation in the 4-bit build, then a non-saturating window
    measure("t5", 2, 0, 100, 0, 1, 142);
    chk("t5_cnt0", 64'(edge_cnt[15:0]), 64'd50);
    chk("t5_avg0", 64'(avg_period[19:0]), 64'd2);
    chk("t5_ovf", 64'(ovf), 64'd0);
    chk("t5_cnt0_w4", 64'(edge_cnt4[3:0]), 64'd15);
    chk("t5_ovf0_w4", 64'(ovf4[0]), 64'd1);
    measure("t6", 20, 0, 100, 0, 1, 142);
    chk("t6_cnt0_w4", 64'(edge_cnt4[3:0]), 64'd5);
    chk("t6_ovf0_w4", 64'(ovf4[0]), 64'd0);
    chk("t6_avg0", 64'(avg_period[19:0]), 64'd20);

    // Window length below 2 never closes a window
    en = 1'b0;
    per[0] = 0;
    per[1] = 0;
    repeat (4) tick();
    win_len = 20'd1;
    per[0] = 10;
    start_gen();
    en = 1'b1;
    v0 = vcount;
    repeat (200) tick();
    chk("idle_no_valid", 64'(vcount), 64'(v0));
    chk("idle_overrun", 64'(overrun), 64'd0);

    // Short window: alternate windows are dropped and overrun sticks
    en = 1'b0;
    per[0] = 0;
    repeat (4) tick();
    win_len = 20'd22;
    sel_a = 3'd0;
    sel_b = 3'd1;
    per[0] = 4;
    per[1] = 0;
    start_gen();
    tick();
    tick();
    en = 1'b1;
    m = cyc;
    wait_valid(m + 100);
    chk("ovr_first_latency", 64'(cyc - m), 64'd64);
    chk("ovr_cnt0_a", 64'(edge_cnt[15:0]), 64'd6);
    chk("ovr_avg0_a", 64'(avg_period[19:0]), 64'd4);
    chk("ovr_flag_a", 64'(overrun), 64'd1);
    tick();
    wait_valid(m + 200);
    chk("ovr_second_latency", 64'(cyc - m), 64'd108);
    chk("ovr_cnt0_b", 64'(edge_cnt[15:0]), 64'd6);
    chk("ovr_avg0_b", 64'(avg_period[19:0]), 64'd4);
    en = 1'b0;
    per[0] = 0;
    repeat (50) tick();
    chk("ovr_sticky", 64'(overrun), 64'd1);

    // Reset in the middle of a divider sequence
    win_len = 20'd100;
    sel_a = 3'd0;
    sel_b = 3'd1;
    per[0] = 10;
    per[1] = 12;
    start_gen();
    tick();
    tick();
    en = 1'b1;
    m = cyc;
    repeat (109) tick();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    per[0] = 0;
    per[1] = 0;
    sig_in = 2'b00;
    #1;
    chk("mid_rst_edge_cnt", 64'(edge_cnt), 64'd0);
    chk("mid_rst_avg", 64'(avg_period), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_overrun", 64'(overrun), 64'd0);
    chk("mid_rst_diff", 64'(diff), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    r = cyc;
    per[0] = 10;
    per[1] = 12;
    start_gen();
    v0 = vcount;
    wait_valid(r + 160);
    chk("post_rst_latency", 64'(cyc - r), 64'd142);
    chk("post_rst_one_valid", 64'(vcount), 64'(v0 + 1));
    chk("post_rst_cnt0", 64'(edge_cnt[15:0]), 64'd10);
    chk("post_rst_avg0", 64'(avg_period[19:0]), 64'd10);
    chk("post_rst_cnt1", 64'(edge_cnt[31:16]), 64'd9);
    chk("post_rst_avg1", 64'(avg_period[39:20]), 64'd12);
    chk("post_rst_diff", 64'(diff), 64'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
